// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready word stream feeding the buffered serial transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, in_valid, input in_ready);
    modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered serial transmitter: input FIFO, runtime parity / stop-bit / divisor, per-frame latched config.
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (0)
// DATA   | DATA_BITS data bits, LSB first
// PARITY | even/odd parity bit
// STOP1  | first stop bit
// STOP2  | optional second stop bit
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               in_if,
    input  logic [1:0]                  parity_mode,
    input  logic                        two_stop,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          level_q;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_eff;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shreg_q, head;
    logic                 par_en_q, par_bit_q, two_q, txd_q, txd_d, frame_done_q;
    logic                 push, pop, empty, adv, last_bit, frame_end;

    assign empty          = (level_q == '0);
    assign in_if.in_ready = (level_q != (AW+1)'(FIFO_DEPTH));
    assign push           = in_if.in_valid && in_if.in_ready;
    assign head           = mem_q[rd_ptr_q];
    assign div_eff        = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
    assign adv            = (state_q != IDLE) && (cnt_q == '0);
    assign last_bit       = (bit_q == BW'(DATA_BITS - 1));
    // START is only ever entered from IDLE or a stop bit, so entering it marks a new frame.
    assign pop            = (state_d == START) && (state_q != START);
    assign frame_end      = adv && ((state_q == STOP2) || (state_q == STOP1 && !two_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            cnt_q        <= '0;
            div_q        <= DIV_WIDTH'(1);
            bit_q        <= '0;
            shreg_q      <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            two_q        <= 1'b0;
            txd_q        <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            txd_q        <= txd_d;
            frame_done_q <= frame_end;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (pop) begin
                shreg_q   <= head;
                bit_q     <= '0;
                div_q     <= div_eff;
                par_en_q  <= ^parity_mode;
                par_bit_q <= (^head) ^ parity_mode[1];
                two_q     <= two_stop;
            end else if (adv && state_q == DATA) begin
                shreg_q <= shreg_q >> 1;
                bit_q   <= bit_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and level are what define the contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_if.in_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = START;
            START:   if (adv) state_d = DATA;
            DATA:    if (adv && last_bit) state_d = par_en_q ? PARITY : STOP1;
            PARITY:  if (adv) state_d = STOP1;
            STOP1:   if (adv) state_d = two_q ? STOP2 : (empty ? IDLE : START);
            STOP2:   if (adv) state_d = empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // txd is registered, so it is computed from the state being entered.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = (state_q == DATA && adv) ? shreg_q[1] : shreg_q[0];
            PARITY:  txd_d = par_bit_q;
            default: txd_d = 1'b1;
        endcase
        cnt_d = cnt_q;
        if (pop)
            cnt_d = div_eff - 1'b1;
        else if (adv)
            cnt_d = div_q - 1'b1;
        else if (state_q != IDLE)
            cnt_d = cnt_q - 1'b1;
    end

    assign txd        = txd_q;
    assign frame_done = frame_done_q;
    assign fifo_level = level_q;
    assign busy       = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: per-cycle line model for single/back-to-back frames, FIFO backpressure decode, async reset.
module tb_uart_tx_fifo;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int DW    = 16;

    typedef logic [DB-1:0] word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    parity_mode;
    logic          two_stop;
    logic [DW-1:0] baud_div;
    logic          txd, busy, frame_done;
    logic [4:0]    fifo_level;

    int n_pass  = 0;
    int n_total = 0;

    bit exp_q[$];
    int end_q[$];

    uart_tx_fifo_if #(.DATA_BITS(DB)) bus ();

    uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .baud_div   (baud_div),
        .txd        (txd),
        .busy       (busy),
        .fifo_level (fifo_level),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected line waveform of one frame, one entry per clock cycle.
    function automatic void add_frame(word_t w, logic [1:0] mode, logic two, int div_raw);
        int d;
        bit bits[$];
        d = (div_raw == 0) ? 1 : div_raw;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(w[i]);
        if (mode == 2'b01) bits.push_back(bit'($countones(w) % 2));
        if (mode == 2'b10) bits.push_back(bit'(($countones(w) + 1) % 2));
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        foreach (bits[i]) for (int r = 0; r < d; r++) exp_q.push_back(bits[i]);
        end_q.push_back(exp_q.size());
    endfunction

    // Pushes words on consecutive edges and checks txd/frame_done/busy every cycle.
    // baud_div switches from div0 to div1 mid-way through the first frame.
    task automatic run_stream(input word_t words[$], input logic [1:0] mode, input logic two,
                              input int div0, input int div1, input string name);
        int  ltot, k;
        logic exp_txd, exp_fd, exp_busy;
        exp_q.delete();
        end_q.delete();
        foreach (words[i]) add_frame(words[i], mode, two, (i == 0) ? div0 : div1);
        ltot        = exp_q.size();
        parity_mode = mode;
        two_stop    = two;
        baud_div    = DW'(div0);
        for (int c = 0; c <= ltot + 1; c++) begin
            @(negedge clk);
            if (c < words.size()) begin
                bus.in_valid = 1'b1;
                bus.in_data  = words[c];
            end else begin
                bus.in_valid = 1'b0;
            end
            if (c == 3) baud_div = DW'(div1);
            @(posedge clk);
            #1;
            if (c == 0) begin
                n_total++;
                if (txd !== 1'b1 || busy !== 1'b1)
                    $display("FAIL %s accept_edge txd=%b busy=%b exp txd=1 busy=1", name, txd, busy);
                else n_pass++;
            end else begin
                k        = c - 1;
                exp_txd  = (k < ltot) ? exp_q[k] : 1'b1;
                exp_busy = (k < ltot);
                exp_fd   = 1'b0;
                foreach (end_q[j]) if (end_q[j] == k) exp_fd = 1'b1;
                n_total++;
                if (txd !== exp_txd) $display("FAIL %s txd k=%0d got %b exp %b", name, k, txd, exp_txd);
                else n_pass++;
                n_total++;
                if (frame_done !== exp_fd) $display("FAIL %s frame_done k=%0d got %b exp %b", name, k, frame_done, exp_fd);
                else n_pass++;
                n_total++;
                if (busy !== exp_busy) $display("FAIL %s busy k=%0d got %b exp %b", name, k, busy, exp_busy);
                else n_pass++;
            end
        end
        n_total++;
        if (fifo_level !== 5'd0) $display("FAIL %s final_level got %0d exp 0", name, fifo_level);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        parity_mode  = 2'b00;
        two_stop     = 1'b0;
        baud_div     = DW'(1);
        repeat (3) @(negedge clk);
        n_total++;
        if (txd !== 1'b1) $display("FAIL reset_txd got %b exp 1", txd); else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_total++;
        if (fifo_level !== 5'd0) $display("FAIL reset_level got %0d exp 0", fifo_level); else n_pass++;
        n_total++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (txd !== 1'b1 || busy !== 1'b0) $display("FAIL post_reset_idle txd=%b busy=%b exp 1 0", txd, busy);
        else n_pass++;
    endtask

    task automatic test_even_one_stop();
        word_t wq[$];
        wq = '{8'h55};
        run_stream(wq, 2'b01, 1'b0, 4, 4, "even_0x55");
    endtask

    task automatic test_odd_two_stop();
        word_t wq[$];
        wq = '{8'h07};
        run_stream(wq, 2'b10, 1'b1, 4, 4, "odd_2stop_0x07");
    endtask

    task automatic test_back_to_back();
        word_t wq[$];
        wq = '{8'hA3, 8'h3C};
        run_stream(wq, 2'b00, 1'b0, 0, 0, "back_to_back_div0");
    endtask

    task automatic test_div_change();
        word_t wq[$];
        wq = '{word_t'($urandom_range(0, 255)), word_t'($urandom_range(0, 255))};
        run_stream(wq, 2'b01, 1'b0, 4, 8, "div_change_4_8");
    endtask

    task automatic test_random();
        word_t wq[$];
        int    n;
        for (int it = 0; it < 6; it++) begin
            wq.delete();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) wq.push_back(word_t'($urandom_range(0, 255)));
            run_stream(wq, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 5), $urandom_range(0, 5), $sformatf("random_%0d", it));
        end
    endtask

    // Producer holds each word until accepted; a line decoder recovers the transmitted words.
    task automatic test_fifo_full();
        localparam int D = 100;
        word_t w[$];
        word_t dec[$];
        word_t rx;
        int    pi, t, cyc;
        bit    acc_now, rx_on, prev, full_seen;
        for (int i = 0; i < 20; i++) w.push_back(word_t'($urandom_range(0, 255)));
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        baud_div    = DW'(D);
        pi = 0; t = 0; cyc = 0; rx = '0;
        rx_on = 1'b0; prev = 1'b1; full_seen = 1'b0;
        while (dec.size() < 20 && cyc < 30000) begin
            @(negedge clk);
            if (pi < 20) begin
                bus.in_valid = 1'b1;
                bus.in_data  = w[pi];
                acc_now      = bus.in_ready;
            end else begin
                bus.in_valid = 1'b0;
                acc_now      = 1'b0;
            end
            if (fifo_level == 5'd16) begin
                n_total++;
                if (bus.in_ready !== 1'b0 || busy !== 1'b1)
                    $display("FAIL full_ready cyc=%0d in_ready=%b busy=%b exp 0 1", cyc, bus.in_ready, busy);
                else begin
                    n_pass++;
                    full_seen = 1'b1;
                end
            end
            @(posedge clk);
            if (acc_now) pi++;
            #1;
            cyc++;
            if (rx_on) t++;
            else if (txd === 1'b0 && prev) begin
                rx_on = 1'b1;
                t     = 0;
            end
            if (rx_on) begin
                if (t == D / 2) begin
                    n_total++;
                    if (txd !== 1'b0) $display("FAIL full_start_bit word=%0d got %b exp 0", dec.size(), txd);
                    else n_pass++;
                end
                for (int j = 1; j <= DB; j++) if (t == j * D + D / 2) rx[j-1] = txd;
                if (t == (DB + 1) * D + D / 2) begin
                    n_total++;
                    if (txd !== 1'b1) $display("FAIL full_stop_bit word=%0d got %b exp 1", dec.size(), txd);
                    else n_pass++;
                    dec.push_back(rx);
                    rx_on = 1'b0;
                end
            end
            prev = txd;
        end
        bus.in_valid = 1'b0;
        n_total++;
        if (full_seen !== 1'b1) $display("FAIL full_seen got %b exp 1", full_seen); else n_pass++;
        n_total++;
        if (pi != 20) $display("FAIL full_accepted got %0d exp 20", pi); else n_pass++;
        n_total++;
        if (dec.size() != 20) $display("FAIL full_decoded_count got %0d exp 20", dec.size()); else n_pass++;
        foreach (dec[i]) begin
            n_total++;
            if (dec[i] !== w[i]) $display("FAIL full_order idx=%0d got %h exp %h", i, dec[i], w[i]);
            else n_pass++;
        end
        repeat (D * 2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        word_t w[4];
        for (int i = 0; i < 4; i++) w[i] = word_t'($urandom_range(0, 255));
        w[0][0]     = 1'b0;
        parity_mode = 2'b01;
        two_stop    = 1'b0;
        baud_div    = DW'(4);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c < 4) begin
                bus.in_valid = 1'b1;
                bus.in_data  = w[c];
            end else bus.in_valid = 1'b0;
            @(posedge clk);
        end
        #1;
        n_total++;
        if (txd !== 1'b0 || fifo_level !== 5'd3)
            $display("FAIL rst_pre txd=%b level=%0d exp 0 3", txd, fifo_level);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (txd !== 1'b1) $display("FAIL rst_async_txd got %b exp 1", txd); else n_pass++;
        n_total++;
        if (fifo_level !== 5'd0) $display("FAIL rst_async_level got %0d exp 0", fifo_level); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL rst_async_busy got %b exp 0", busy); else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL rst_async_in_ready got %b exp 1", bus.in_ready); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0)
                $display("FAIL rst_no_resume c=%0d txd=%b busy=%b frame_done=%b exp 1 0 0", c, txd, busy, frame_done);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_even_one_stop();
        test_odd_two_stop();
        test_back_to_back();
        test_div_change();
        test_random();
        test_fifo_full();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
